// File: rtl/run_length_detector_if.sv
// Serial run detector bus: sampled data,
// qualifiers and detection outputs.
interface run_length_detector_if #(
  parameter int CNT_W = 8
);
  logic             x;
  logic             en;
  logic [1:0]       mode;
  logic             overlap;
  logic             clr_cnt;
  logic             z;
  logic             z_q;
  logic             run_bit;
  logic [CNT_W-1:0] det_cnt;

  modport master (
    output x, en, mode, overlap, clr_cnt,
    input  z, z_q, run_bit, det_cnt
  );

  modport slave (
    input  x, en, mode, overlap, clr_cnt,
    output z, z_q, run_bit, det_cnt
  );
endinterface

// File: rtl/run_length_detector.sv
// Parametrised run detector: flags RUN_LEN
// equal sampled bits with a saturating hit count.
module run_length_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic rst,
  run_length_detector_if.slave b
);
  localparam int CW = $clog2(RUN_LEN);
  localparam logic [CW-1:0] TOP =
    CW'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } st_t;

  st_t              st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             zq_q;
  logic [CNT_W-1:0] det_q, det_d;
  logic             hit;
  logic             allow;
  logic             z;

  // state, run tracking and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= EMPTY;
      cnt_q  <= '0;
      last_q <= 1'b0;
      zq_q   <= 1'b0;
      det_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      zq_q   <= z;
      det_q  <= det_d;
    end
  end

  // next state: run length follows sampled bits only
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (b.en) begin
      unique case (st_q)
        EMPTY: begin
          st_d   = TRACK;
          last_d = b.x;
          cnt_d  = CW'(1);
        end
        TRACK: begin
          if (b.x != last_q) begin
            last_d = b.x;
            cnt_d  = CW'(1);
          end else if (cnt_q != TOP) begin
            cnt_d = cnt_q + 1'b1;
          end else if (z && !b.overlap) begin
            st_d  = EMPTY;
            cnt_d = '0;
          end
        end
        default: begin
          st_d = EMPTY;
        end
      endcase
    end
  end

  // outputs: Mealy detect and saturating count
  always_comb begin
    allow = 1'b0;
    unique case (1'b1)
      b.mode[1]:
        allow = 1'b1;
      (!b.mode[1] && !b.mode[0]):
        allow = b.x;
      (!b.mode[1] && b.mode[0]):
        allow = !b.x;
      default:
        allow = 1'b0;
    endcase
    hit = !rst && b.en &&
          (st_q == TRACK) &&
          (b.x == last_q) &&
          (cnt_q == TOP);
    z = hit && allow;
    det_d = det_q;
    if (b.clr_cnt) begin
      det_d = '0;
    end else if (z && det_q != CMAX) begin
      det_d = det_q + 1'b1;
    end
  end

  assign b.z       = z;
  assign b.z_q     = zq_q;
  assign b.run_bit = last_q;
  assign b.det_cnt = det_q;
endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: table vectors,
// hand sequences and a random run-length model.
module tb_run_length_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_length_detector_if #(.CNT_W(8)) i3();
  run_length_detector_if #(.CNT_W(2)) i4();

  run_length_detector #(
    .RUN_LEN(3), .CNT_W(8)
  ) u3 (.clk(clk), .rst(rst), .b(i3));

  run_length_detector #(
    .RUN_LEN(4), .CNT_W(2)
  ) u4 (.clk(clk), .rst(rst), .b(i4));

  int total = 0;
  int bad   = 0;

  int   len [2];
  int   mcnt[2];
  logic lb  [2];
  logic mzq [2];
  int   rl  [2] = '{3, 4};
  int   mx  [2] = '{255, 3};

  typedef struct {
    logic       r;
    logic       x;
    logic       en;
    logic [1:0] md;
    logic       ov;
    logic       ez;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic r, x, en,
    input logic [1:0] md,
    input logic ov, ez,
    input int ec
  );
    vec_t t;
    t.r = r; t.x = x; t.en = en;
    t.md = md; t.ov = ov;
    t.ez = ez; t.ec = ec;
    return t;
  endfunction

  task automatic chk(
    input string n,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t",
               n, act, exp, $time);
    end
  endtask

  // reference: plain run length since last restart
  function automatic logic mz(
    input int k, input logic x, en,
    input logic [1:0] md
  );
    int   nl;
    logic al;
    if (!en) return 1'b0;
    nl = (len[k] != 0 && x == lb[k]) ?
         len[k] + 1 : 1;
    al = md[1] || (md == 2'b00 && x) ||
         (md == 2'b01 && !x);
    return (nl >= rl[k]) && al;
  endfunction

  task automatic mupd(
    input int k, input logic x, en,
    input logic [1:0] md,
    input logic ov, clr
  );
    logic zz;
    zz = mz(k, x, en, md);
    if (en) begin
      len[k] = (len[k] != 0 && x == lb[k]) ?
               len[k] + 1 : 1;
      lb[k] = x;
      if (zz && !ov) len[k] = 0;
    end
    mzq[k] = zz;
    if (clr) mcnt[k] = 0;
    else if (zz && mcnt[k] < mx[k])
      mcnt[k] = mcnt[k] + 1;
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      len[k] = 0; mcnt[k] = 0;
      lb[k] = 1'b0; mzq[k] = 1'b0;
    end
  endtask

  task automatic drive(
    input logic x, en,
    input logic [1:0] md,
    input logic ov, clr
  );
    i3.x = x; i3.en = en; i3.mode = md;
    i3.overlap = ov; i3.clr_cnt = clr;
    i4.x = x; i4.en = en; i4.mode = md;
    i4.overlap = ov; i4.clr_cnt = clr;
  endtask

  task automatic step(
    input logic x, en,
    input logic [1:0] md,
    input logic ov, clr,
    output logic z3, z4,
    output logic [7:0] c3, c4
  );
    drive(x, en, md, ov, clr);
    @(negedge clk);
    z3 = i3.z; z4 = i4.z;
    c3 = i3.det_cnt;
    c4 = {6'd0, i4.det_cnt};
    chk("m3_z", 32'(i3.z), 32'(mz(0, x, en, md)));
    chk("m4_z", 32'(i4.z), 32'(mz(1, x, en, md)));
    chk("m3_zq", 32'(i3.z_q), 32'(mzq[0]));
    chk("m4_zq", 32'(i4.z_q), 32'(mzq[1]));
    chk("m3_rb", 32'(i3.run_bit), 32'(lb[0]));
    chk("m4_rb", 32'(i4.run_bit), 32'(lb[1]));
    chk("m3_cnt", 32'(i3.det_cnt), 32'(mcnt[0]));
    chk("m4_cnt", 32'(i4.det_cnt), 32'(mcnt[1]));
    mupd(0, x, en, md, ov, clr);
    mupd(1, x, en, md, ov, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst3_z", 32'(i3.z), 0);
    chk("rst4_z", 32'(i4.z), 0);
    chk("rst3_zq", 32'(i3.z_q), 0);
    chk("rst3_rb", 32'(i3.run_bit), 0);
    chk("rst3_cnt", 32'(i3.det_cnt), 0);
    chk("rst4_cnt", 32'(i4.det_cnt), 0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    mreset();
  endtask

  logic       z3, z4;
  logic [7:0] c3, c4;
  logic       px;
  int         e4[9] = '{0, 0, 0, 0, 1, 2, 3, 3, 3};

  initial begin
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    mreset();

    // overlap, either polarity
    tbl.push_back(v(1, 0, 0, 2, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 2, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 2, 1, 0, 0));
    tbl.push_back(v(0, 1, 1, 2, 1, 1, 0));
    tbl.push_back(v(0, 1, 1, 2, 1, 1, 1));
    tbl.push_back(v(0, 0, 1, 2, 1, 0, 2));
    tbl.push_back(v(0, 0, 1, 2, 1, 0, 2));
    tbl.push_back(v(0, 0, 1, 2, 1, 1, 2));
    tbl.push_back(v(0, 0, 1, 2, 1, 1, 3));
    tbl.push_back(v(0, 0, 0, 2, 1, 0, 4));
    // non-overlap ones, zero run masked
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(v(0, 1, 1, 0, 0,
        (i == 2 || i == 5), (i > 2) + (i > 5)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 2));
    // en gap does not break a run
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1));
    // reset mid-run discards run and count
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) begin
      if (tbl[i].r) begin
        do_reset();
      end else begin
        step(tbl[i].x, tbl[i].en, tbl[i].md,
             tbl[i].ov, 1'b0, z3, z4, c3, c4);
        chk($sformatf("tv%0d_z", i),
            32'(z3), 32'(tbl[i].ez));
        chk($sformatf("tv%0d_cnt", i),
            32'(c3), 32'(tbl[i].ec));
      end
    end

    // RUN_LEN=4, zero runs only
    do_reset();
    begin
      logic [9:0] s;
      s = 10'b1100010000;
      for (int i = 0; i < 10; i++) begin
        step(s[9-i], 1'b1, 2'b01, 1'b0, 1'b0,
             z3, z4, c3, c4);
        chk($sformatf("r4_z%0d", i),
            32'(z4), 32'(i == 9));
      end
    end
    step(1'b0, 1'b0, 2'b01, 1'b0, 1'b0,
         z3, z4, c3, c4);
    chk("r4_cnt", 32'(c4), 1);

    // 2-bit counter saturation and clear vs z
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 2'b10, 1'b1, 1'b0,
           z3, z4, c3, c4);
      chk($sformatf("sat%0d", i),
          32'(c4), 32'(e4[i]));
    end
    step(1'b1, 1'b1, 2'b10, 1'b1, 1'b1,
         z3, z4, c3, c4);
    chk("clr_z", 32'(z4), 1);
    step(1'b1, 1'b1, 2'b10, 1'b1, 1'b0,
         z3, z4, c3, c4);
    chk("clr_cnt", 32'(c4), 0);

    // random stimulus against the model
    do_reset();
    px = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) px = ~px;
        step(px, ($urandom_range(0, 9) < 8),
             2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 39) == 0),
             z3, z4, c3, c4);
      end
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
